// File: rtl/regfile_pkg.sv
// Shared constants and bus-slice helpers for the multi-port register file.
// Optional feature macro used by the register file: REGFILE_BYPASS_EN.

package regfile_pkg;

    // Default geometry of the MIPS register file
    localparam int unsigned DEFAULT_DW     = 32;
    localparam int unsigned DEFAULT_AW     = 5;
    localparam int unsigned DEFAULT_NUM_RD = 2;

    // Hardwired-zero register address
    localparam int unsigned ZERO_REG = 0;

endpackage

// Select element idx of width w from a flattened bus
`define RF_SLICE(bus, idx, w) bus[(idx)*(w) +: (w)]

// File: rtl/regfile_read_port.sv
// One read port of the register file: read mux, busy lookup and, when
// REGFILE_BYPASS_EN is defined, same-cycle write bypass.
// Write enables arriving here are already qualified (non-zero address, not in reset).

module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int unsigned DW = DEFAULT_DW,
    parameter int unsigned AW = DEFAULT_AW
) (
    input  logic [AW-1:0]     ra,
    input  logic [DW-1:0]     mem [2**AW],
    input  logic [2**AW-1:0]  busy,
`ifdef REGFILE_BYPASS_EN
    input  logic              we0,
    input  logic [AW-1:0]     wa0,
    input  logic [DW-1:0]     wd0,
    input  logic              we1,
    input  logic [AW-1:0]     wa1,
    input  logic [DW-1:0]     wd1,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_addr,
`endif
    output logic [DW-1:0]     rd,
    output logic              rd_busy
);

    // Select stored data and busy bit, overridden by an in-flight write when bypassing
    always_comb begin
        rd      = (ra == AW'(ZERO_REG)) ? '0 : mem[ra];
        rd_busy = busy[ra];
`ifdef REGFILE_BYPASS_EN
        if (ra != AW'(ZERO_REG)) begin
            // Port 1 wins, matching the storage write priority
            if (we1 && (wa1 == ra)) begin
                rd      = wd1;
                rd_busy = iss_en && (iss_addr == ra);
            end else if (we0 && (wa0 == ra)) begin
                rd      = wd0;
                rd_busy = iss_en && (iss_addr == ra);
            end
        end
`endif
    end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file: NUM_RD combinational read ports, two write ports,
// per-register busy scoreboard. Register 0 reads as zero and is never busy.
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write-to-read bypass).

module register_file_mp
    import regfile_pkg::*;
#(
    parameter int unsigned DW     = DEFAULT_DW,
    parameter int unsigned AW     = DEFAULT_AW,
    parameter int unsigned NUM_RD = DEFAULT_NUM_RD
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we0,
    input  logic [AW-1:0]        wa0,
    input  logic [DW-1:0]        wd0,
    input  logic                 we1,
    input  logic [AW-1:0]        wa1,
    input  logic [DW-1:0]        wd1,
    input  logic [NUM_RD*AW-1:0] ra,
    output logic [NUM_RD*DW-1:0] rd,
    output logic [NUM_RD-1:0]    rd_busy,
    input  logic                 iss_en,
    input  logic [AW-1:0]        iss_addr
);

    localparam int unsigned Depth = 2**AW;

    logic [DW-1:0]    mem_q [Depth];
    logic [DW-1:0]    mem_d [Depth];
    logic [Depth-1:0] busy_q;
    logic [Depth-1:0] busy_d;

    logic wr0;
    logic wr1;
    logic iss;

    assign wr0 = we0 && (wa0 != AW'(ZERO_REG));
    assign wr1 = we1 && (wa1 != AW'(ZERO_REG));
    assign iss = iss_en && (iss_addr != AW'(ZERO_REG));

    // Next state: port 1 overrides port 0, issue overrides retirement
    always_comb begin
        mem_d  = mem_q;
        busy_d = busy_q;
        if (wr0) begin
            mem_d[wa0]  = wd0;
            busy_d[wa0] = 1'b0;
        end
        if (wr1) begin
            mem_d[wa1]  = wd1;
            busy_d[wa1] = 1'b0;
        end
        if (iss) begin
            busy_d[iss_addr] = 1'b1;
        end
        mem_d[0]  = '0;
        busy_d[0] = 1'b0;
    end

    // Storage and scoreboard, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            mem_q  <= mem_d;
            busy_q <= busy_d;
        end
    end

`ifdef REGFILE_BYPASS_EN
    // Bypass sources are masked in reset so outputs stay zero while rst is low
    logic byp_we0;
    logic byp_we1;
    logic byp_iss;

    assign byp_we0 = wr0 && rst;
    assign byp_we1 = wr1 && rst;
    assign byp_iss = iss && rst;
`endif

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        regfile_read_port #(
            .DW (DW),
            .AW (AW)
        ) u_read_port (
            .ra       (`RF_SLICE(ra, i, AW)),
            .mem      (mem_q),
            .busy     (busy_q),
`ifdef REGFILE_BYPASS_EN
            .we0      (byp_we0),
            .wa0      (wa0),
            .wd0      (wd0),
            .we1      (byp_we1),
            .wa1      (wa1),
            .wd1      (wd1),
            .iss_en   (byp_iss),
            .iss_addr (iss_addr),
`endif
            .rd       (`RF_SLICE(rd, i, DW)),
            .rd_busy  (rd_busy[i])
        );
    end

endmodule

// File: tb/tb_register_file_mp.sv
// Scoreboard bench for register_file_mp: a default-geometry instance and a
// DW=16/AW=3/NUM_RD=4 instance share clock and reset.

module tb_register_file_mp;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    // Default instance (DW=32, AW=5, NUM_RD=2)
    logic        a_we0, a_we1, a_iss;
    logic [4:0]  a_wa0, a_wa1, a_iss_addr;
    logic [31:0] a_wd0, a_wd1;
    logic [9:0]  a_ra;
    logic [63:0] a_rd;
    logic [1:0]  a_busy;

    // Small instance (DW=16, AW=3, NUM_RD=4)
    logic        b_we0, b_we1, b_iss;
    logic [2:0]  b_wa0, b_wa1, b_iss_addr;
    logic [15:0] b_wd0, b_wd1;
    logic [11:0] b_ra;
    logic [63:0] b_rd;
    logic [3:0]  b_busy;

    register_file_mp u_dut_a (
        .clk      (clk),
        .rst      (rst),
        .we0      (a_we0),
        .wa0      (a_wa0),
        .wd0      (a_wd0),
        .we1      (a_we1),
        .wa1      (a_wa1),
        .wd1      (a_wd1),
        .ra       (a_ra),
        .rd       (a_rd),
        .rd_busy  (a_busy),
        .iss_en   (a_iss),
        .iss_addr (a_iss_addr)
    );

    register_file_mp #(
        .DW     (16),
        .AW     (3),
        .NUM_RD (4)
    ) u_dut_b (
        .clk      (clk),
        .rst      (rst),
        .we0      (b_we0),
        .wa0      (b_wa0),
        .wd0      (b_wd0),
        .we1      (b_we1),
        .wa1      (b_wa1),
        .wd1      (b_wd1),
        .ra       (b_ra),
        .rd       (b_rd),
        .rd_busy  (b_busy),
        .iss_en   (b_iss),
        .iss_addr (b_iss_addr)
    );

    typedef struct {
        string       name;
        int          inst;
        int          port;
        bit          is_busy;
        logic [31:0] exp;
    } chk_t;

    chk_t q[$];
    int   n_pass = 0;
    int   n_tot  = 0;

    task automatic chk(input string n, input int inst, input int port, input bit b,
                       input logic [31:0] e);
        chk_t c;
        c.name = n; c.inst = inst; c.port = port; c.is_busy = b; c.exp = e;
        q.push_back(c);
    endtask

    // Inputs change 1 time unit after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_we0 = 0; a_we1 = 0; a_iss = 0;
        b_we0 = 0; b_we1 = 0; b_iss = 0;
    endtask

    task automatic set_a_ra(input int p, input logic [4:0] addr);
        a_ra[p*5 +: 5] = addr;
    endtask

    // Monitor: outputs are stable at the falling edge; compare everything queued
    initial begin
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                chk_t        c;
                logic [31:0] act;
                c = q.pop_front();
                if (c.inst == 0)
                    act = c.is_busy ? {31'd0, a_busy[c.port]} : a_rd[c.port*32 +: 32];
                else
                    act = c.is_busy ? {31'd0, b_busy[c.port]} : {16'd0, b_rd[c.port*16 +: 16]};
                n_tot++;
                if (act === c.exp) n_pass++;
                else $display("FAIL %s: got %0h, expected %0h", c.name, act, c.exp);
            end
        end
    end

    initial begin
        rst = 1'b0;
        idle();
        a_wa0 = '0; a_wa1 = '0; a_wd0 = '0; a_wd1 = '0; a_iss_addr = '0; a_ra = '0;
        b_wa0 = '0; b_wa1 = '0; b_wd0 = '0; b_wd1 = '0; b_iss_addr = '0; b_ra = '0;
        set_a_ra(0, 5'd5);
        set_a_ra(1, 5'd7);
        #2;
        chk("reset_rd", 0, 0, 0, 32'h0);
        chk("reset_busy", 0, 1, 1, 32'h0);
        step();
        rst = 1'b1;

        // Reset clear
        a_we0 = 1; a_wa0 = 5'd5; a_wd0 = 32'hDEADBEEF;
        a_iss = 1; a_iss_addr = 5'd7;
        step();
        idle();
        chk("pre_reset_r5", 0, 0, 0, 32'hDEADBEEF);
        chk("pre_reset_busy_r7", 0, 1, 1, 32'h1);
        step();
        rst = 1'b0;
        chk("async_reset_r5", 0, 0, 0, 32'h0);
        chk("async_reset_busy_r7", 0, 1, 1, 32'h0);
        step();
        rst = 1'b1;
        chk("reset_hold_r5", 0, 0, 0, 32'h0);
        step();
        chk("post_release_r5", 0, 0, 0, 32'h0);
        chk("post_release_busy_r7", 0, 1, 1, 32'h0);

        // Zero register
        set_a_ra(0, 5'd0);
        set_a_ra(1, 5'd0);
        a_we0 = 1; a_wa0 = 5'd0; a_wd0 = 32'hFFFFFFFF;
        a_iss = 1; a_iss_addr = 5'd0;
        step();
        idle();
        chk("zero_rd0", 0, 0, 0, 32'h0);
        chk("zero_rd1", 0, 1, 0, 32'h0);
        chk("zero_busy", 0, 0, 1, 32'h0);
        step();
        chk("zero_rd_later", 0, 0, 0, 32'h0);
        chk("zero_busy_later", 0, 1, 1, 32'h0);

        // Dual-write collision: port 1 wins
        a_we0 = 1; a_wa0 = 5'd9; a_wd0 = 32'h11111111;
        a_we1 = 1; a_wa1 = 5'd9; a_wd1 = 32'h22222222;
        step();
        idle();
        set_a_ra(0, 5'd9);
        set_a_ra(1, 5'd9);
        chk("collision_p0", 0, 0, 0, 32'h22222222);
        chk("collision_p1", 0, 1, 0, 32'h22222222);
        step();

        // Scoreboard set/clear
        set_a_ra(0, 5'd3);
        set_a_ra(1, 5'd3);
        a_iss = 1; a_iss_addr = 5'd3;
        step();
        idle();
        for (int i = 0; i < 3; i++) begin
            chk("busy_hold", 0, i % 2, 1, 32'h1);
            step();
        end
        a_we1 = 1; a_wa1 = 5'd3; a_wd1 = 32'h1234;
        a_iss = 1; a_iss_addr = 5'd3;
        step();
        idle();
        chk("set_wins_data", 0, 0, 0, 32'h1234);
        chk("set_wins_busy", 0, 1, 1, 32'h1);
        step();
        a_we0 = 1; a_wa0 = 5'd3; a_wd0 = 32'h5678;
        step();
        idle();
        chk("clear_data", 0, 1, 0, 32'h5678);
        chk("clear_busy", 0, 0, 1, 32'h0);
        step();

        // Bypass (or its absence)
        set_a_ra(0, 5'd12);
        set_a_ra(1, 5'd12);
        a_we0 = 1; a_wa0 = 5'd12; a_wd0 = 32'h0BADF00D;
        a_iss = 1; a_iss_addr = 5'd12;
        step();
        idle();
        chk("byp_setup_data", 0, 0, 0, 32'h0BADF00D);
        chk("byp_setup_busy", 0, 0, 1, 32'h1);
        step();
        a_we0 = 1; a_wa0 = 5'd12; a_wd0 = 32'hCAFEF00D;
`ifdef REGFILE_BYPASS_EN
        chk("byp_pre_edge_data", 0, 0, 0, 32'hCAFEF00D);
        chk("byp_pre_edge_busy", 0, 0, 1, 32'h0);
`else
        chk("nobyp_pre_edge_data", 0, 0, 0, 32'h0BADF00D);
        chk("nobyp_pre_edge_busy", 0, 0, 1, 32'h1);
`endif
        step();
        idle();
        chk("byp_post_edge_data", 0, 0, 0, 32'hCAFEF00D);
        chk("byp_post_edge_busy", 0, 1, 1, 32'h0);
        step();
        a_we0 = 1; a_wa0 = 5'd12; a_wd0 = 32'hAAAA0000;
        a_we1 = 1; a_wa1 = 5'd12; a_wd1 = 32'hBBBB1111;
`ifdef REGFILE_BYPASS_EN
        chk("byp_prio_pre_edge", 0, 1, 0, 32'hBBBB1111);
`else
        chk("nobyp_prio_pre_edge", 0, 1, 0, 32'hCAFEF00D);
`endif
        step();
        idle();
        chk("prio_post_edge", 0, 1, 0, 32'hBBBB1111);
        step();

        // Small geometry: fill r1..r7 with index * 0x0101
        for (int i = 1; i <= 7; i += 2) begin
            b_we0 = 1; b_wa0 = 3'(i); b_wd0 = 16'(i * 16'h0101);
            b_we1 = (i < 7); b_wa1 = 3'(i + 1); b_wd1 = 16'((i + 1) * 16'h0101);
            step();
        end
        idle();
        b_ra = {3'd7, 3'd6, 3'd4, 3'd1};
        chk("p4_a_port0", 1, 0, 0, 32'h0101);
        chk("p4_a_port1", 1, 1, 0, 32'h0404);
        chk("p4_a_port2", 1, 2, 0, 32'h0606);
        chk("p4_a_port3", 1, 3, 0, 32'h0707);
        step();
        b_ra = {3'd5, 3'd3, 3'd2, 3'd0};
        chk("p4_b_port0", 1, 0, 0, 32'h0000);
        chk("p4_b_port1", 1, 1, 0, 32'h0202);
        chk("p4_b_port2", 1, 2, 0, 32'h0303);
        chk("p4_b_port3", 1, 3, 0, 32'h0505);
        chk("p4_b_busy3", 1, 3, 1, 32'h0);
        step();

        @(negedge clk);
        #1;
        n_tot++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending checks, expected 0", q.size());
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
- Parametrised multi-port register file for the MIPS datapath, successor to the single-write, two-read register file.
- NUM_RD read ports and two write ports, so a second writeback path (e.g. a load unit) can retire alongside the ALU.
- Per-register busy scoreboard drives the hazard unit.
- Register 0 is hardwired to zero and never busy.

Parameters:
- DW, 32, data width in bits.
- AW, 5, address width; depth = 2**AW registers.
- NUM_RD, 2, number of read ports (1..8).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  asynchronous active-low reset.
- we0  input  1  write enable, port 0.
- wa0  input  AW  write address, port 0.
- wd0  input  DW  write data, port 0.
- we1  input  1  write enable, port 1.
- wa1  input  AW  write address, port 1.
- wd1  input  DW  write data, port 1.
- ra  input  NUM_RD*AW  read addresses, port i at bits [i*AW +: AW].
- rd  output  NUM_RD*DW  read data, port i at bits [i*DW +: DW].
- rd_busy  output  NUM_RD  busy bit of the register addressed by read port i.
- iss_en  input  1  issue: mark destination register busy.
- iss_addr  input  AW  destination register being issued.

Behaviour:
Reset:
- rst low clears every register and every busy bit immediately, with no clock needed.
- While rst is low, rd = 0 and rd_busy = 0 on all ports.
- Deassertion takes effect at the next rising clock edge.

Writes:
- Write takes effect on the rising edge: weN & (waN != 0) stores wdN.
- Writes to address 0 are ignored; reads of address 0 always return 0.
- If both ports write the same non-zero address in one cycle, port 1 wins.

Reads:
- Reads are combinational from stored state, with zero clock latency.
- Without bypass, data written at edge k is visible after edge k.

Scoreboard:
- One busy bit per register; busy[0] is constantly 0.
- At the edge, busy[iss_addr] is set when iss_en and iss_addr != 0.
- At the edge, busy[waN] is cleared when weN and waN != 0 (either port).
- If issue and a write hit the same address in the same cycle, set wins: a new producer supersedes the retiring one.
- Both ports writing different addresses clears both bits.
- Issuing to an already-busy register keeps it busy; there is no counting and no error flag.
- rd_busy[i] = busy[ra_i], combinational.

No handshake:
- Writes always succeed.
- Stalling on rd_busy is the hazard unit's responsibility.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - Read port i returns the same-cycle write data when weN & (waN == ra_i) & (ra_i != 0); port 1 has priority over port 0.
  - rd_busy[i] is forced 0 in that case, unless iss_en targets the same address that cycle.
  - This gives write-then-read in the same cycle without a stall.
- Undefined:
  - Reads see only stored state.
  - rd_busy reflects the registered busy bits only.
- Reset behaviour is identical in both builds.

Decomposition:
- Shared package/header (regfile_pkg) holds:
  - default DW/AW/NUM_RD constants;
  - ZERO_REG address constant (0);
  - port-slice helper macros for flattened ra/rd buses.
- One natural sub-module, regfile_read_port: a single read mux plus bypass compare plus busy lookup, generated NUM_RD times.
- Storage and scoreboard stay in the top module.

Test Plan:
- Reset clear:
  - Write 0xDEADBEEF to r5, issue r7, then pulse rst low mid-cycle (no edge).
  - Required: rd for r5 = 0 and rd_busy for r7 = 0 immediately.
  - Required: still 0 after reset release.
- Zero register:
  - we0 = 1, wa0 = 0, wd0 = 0xFFFFFFFF; iss_en with iss_addr = 0.
  - Required: read r0 = 0, rd_busy = 0 on the following cycles.
- Dual-write collision:
  - we0 (r9 = 0x11111111) and we1 (r9 = 0x22222222) on the same edge.
  - Required: r9 = 0x22222222 on all NUM_RD ports.
- Scoreboard set/clear:
  - Issue r3, hold 3 cycles; required: rd_busy = 1 throughout.
  - Then we1 writes r3 = 0x1234 with iss_en for r3 in the same cycle; required: r3 = 0x1234 and still busy.
  - Then a plain write to r3; required: busy = 0.
- Bypass, built with REGFILE_BYPASS_EN:
  - ra0 = r12, we0 writes r12 = 0xCAFEF00D in the same cycle.
  - Required: rd port 0 = 0xCAFEF00D before the edge and rd_busy[0] = 0.
  - Without the macro: old value before the edge, new value after it.
- Parametrisation:
  - DW = 16, AW = 3, NUM_RD = 4.
  - Fill r1..r7 with their index x 0x0101; read all four ports with distinct addresses.
  - Required: each port returns its matching value with no cross-port interference.
